vram_write_ctrl: RTL and testbench

- Owns the single write port of the frame-buffer RAM: `WEN`, x/y address and 3-bit colour index.
- Shares that port between two pixel writers, A and B (maze/pellet renderer and sprite renderer), with round-robin arbitration.
- Contains a full-screen clear sequencer that takes priority and fills every pixel with a fixed index.
- Sits between the renderers and the frame buffer; all outputs are registered so they can drive the RAM write port directly.

---
 rtl/vram_write_ctrl.sv | 173 +++++++++++++++++
 tb/tb_vram_write_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vram_write_ctrl.sv
// Frame-buffer write-port owner: round-robin arbiter for two pixel writers plus
// a full-screen clear sequencer. Optional drop counter: VRAM_WRITE_CTRL_DROP_CNT_EN.
module vram_write_ctrl #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int AW          = 11,
    parameter int DW          = 3,
    parameter int CLEAR_INDEX = 0
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef VRAM_WRITE_CTRL_DROP_CNT_EN
    output logic [15:0]   drop_cnt,
`endif
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_x,
    input  logic [AW-1:0] a_y,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_x,
    input  logic [AW-1:0] b_y,
    input  logic [DW-1:0] b_data,
    output logic          wen,
    output logic [AW-1:0] waddr_x,
    output logic [AW-1:0] waddr_y,
    output logic [DW-1:0] wdata
);

    typedef enum logic {IDLE, CLEAR} state_e;

    localparam logic [AW-1:0] X_LAST = AW'(H_RES - 1);
    localparam logic [AW-1:0] Y_LAST = AW'(V_RES - 1);

    state_e        state_q, state_d;
    logic          grant_b_q, grant_b_d;   // last granted writer was B
    logic [AW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] wx_q, wx_d, wy_q, wy_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic          a_xfer, b_xfer, xfer, in_range;
    logic [AW-1:0] sel_x, sel_y;
    logic [DW-1:0] sel_data;

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state_q == IDLE && !clear_start) begin
            if (a_valid && (!b_valid || grant_b_q))
                a_ready = 1'b1;
            else if (b_valid)
                b_ready = 1'b1;
        end
        a_xfer   = a_valid && a_ready;
        b_xfer   = b_valid && b_ready;
        xfer     = a_xfer || b_xfer;
        sel_x    = b_xfer ? b_x    : a_x;
        sel_y    = b_xfer ? b_y    : a_y;
        sel_data = b_xfer ? b_data : a_data;
        // Widened compare so H_RES == 2**AW still works.
        in_range = ({1'b0, sel_x} < (AW+1)'(H_RES)) && ({1'b0, sel_y} < (AW+1)'(V_RES));
    end

    always_comb begin
        state_d   = state_q;
        grant_b_d = grant_b_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        wen_d     = 1'b0;
        wx_d      = wx_q;
        wy_d      = wy_q;
        wd_d      = wd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (xfer) begin
                    grant_b_d = b_xfer;
                    if (in_range) begin
                        wen_d = 1'b1;
                        wx_d  = sel_x;
                        wy_d  = sel_y;
                        wd_d  = sel_data;
                    end
                end
            end
            CLEAR: begin
                wen_d = 1'b1;
                wx_d  = cx_q;
                wy_d  = cy_q;
                wd_d  = DW'(CLEAR_INDEX);
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        cy_d    = '0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef VRAM_WRITE_CTRL_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (state_q == IDLE && clear_start)
            drop_d = '0;
        else if (xfer && !in_range && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_b_q <= 1'b1;
            cx_q      <= '0;
            cy_q      <= '0;
            wen_q     <= 1'b0;
            wx_q      <= '0;
            wy_q      <= '0;
            wd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_b_q <= grant_b_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            wen_q     <= wen_d;
            wx_q      <= wx_d;
            wy_q      <= wy_d;
            wd_q      <= wd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign wen        = wen_q;
    assign waddr_x    = wx_q;
    assign waddr_y    = wy_q;
    assign wdata      = wd_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;

endmodule

// File: tb/tb_vram_write_ctrl.sv
// Scoreboard bench for vram_write_ctrl on a 4x3 screen; expected writes are
// queued by the stimulus and popped by a negedge monitor.
module tb_vram_write_ctrl;
    localparam int AW = 11;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_start = 1'b0;
    logic          clear_busy, clear_done;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          wen;
    logic [AW-1:0] waddr_x, waddr_y;
    logic [DW-1:0] wdata;
`ifdef VRAM_WRITE_CTRL_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    vram_write_ctrl #(.H_RES(4), .V_RES(3), .AW(AW), .DW(DW), .CLEAR_INDEX(0)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef VRAM_WRITE_CTRL_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_data(b_data),
        .wen(wen), .waddr_x(waddr_x), .waddr_y(waddr_y), .wdata(wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic [AW+AW+DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input int y, input int d);
        exp_q.push_back({AW'(x), AW'(y), DW'(d)});
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (clear_done) done_cnt++;
            if (clear_busy) begin
                busy_cnt++;
                check("ready_in_clear", {30'd0, a_ready, b_ready}, 32'd0);
            end
            if (a_ready && b_ready) check("one_ready", 32'd1, 32'd0);
            if (wen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {waddr_x, waddr_y, wdata}, 32'd0);
                    failures += (waddr_x == 0 && waddr_y == 0 && wdata == 0) ? 1 : 0;
                end else begin
                    check("write", {waddr_x, waddr_y, wdata}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int busy_snap;
        #2;
        check("rst_wen",   wen, 0);
        check("rst_addr",  {waddr_x, waddr_y, wdata}, 0);
        check("rst_flags", {clear_busy, clear_done}, 0);
        tick(); tick();
        rst_n = 1'b1;

        // Single A write.
        tick();
        a_valid = 1; a_x = 2; a_y = 1; a_data = 3;
        #1 check("a_single_ready", {a_ready, b_ready}, 2'b10);
        push(2, 1, 3);
        tick();
        a_valid = 0;
        tick();
        check("wen_drops", wen, 0);

        // Both valid for 4 cycles; last grant was A so B, A, B, A.
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_x = AW'(i); a_y = 0; a_data = 1;
            b_valid = 1; b_x = AW'(i); b_y = 2; b_data = 6;
            #1;
            if (i % 2 == 0) begin
                check("rr_grant_b", {a_ready, b_ready}, 2'b01);
                push(i, 2, 6);
            end else begin
                check("rr_grant_a", {a_ready, b_ready}, 2'b10);
                push(i, 0, 1);
            end
            tick();
        end
        a_valid = 0; b_valid = 0;

        // Out-of-range pixels are accepted but never written; corner is written.
        a_valid = 1; a_x = 4; a_y = 0; a_data = 2;
        #1 check("oor_x_ready", a_ready, 1);
        tick();
        a_valid = 0; b_valid = 1; b_x = 0; b_y = 3; b_data = 2;
        #1 check("oor_y_ready", b_ready, 1);
        tick();
        b_valid = 0; a_valid = 1; a_x = 640; a_y = 1; a_data = 1;
        #1 check("oor_640_ready", a_ready, 1);
        tick();
        a_x = 3; a_y = 2; a_data = 7;
        #1 check("corner_ready", a_ready, 1);
        push(3, 2, 7);
        tick();
        a_valid = 0;
`ifdef VRAM_WRITE_CTRL_DROP_CNT_EN
        check("drop_cnt", drop_cnt, 3);
`endif
        tick();

        // Clear with a simultaneous A request; A must wait for busy to fall.
        busy_cnt = 0;
        clear_start = 1; a_valid = 1; a_x = 1; a_y = 1; a_data = 4;
        #1 check("start_blocks_a", {a_ready, b_ready}, 0);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                push(x, y, 0);
        tick();
        clear_start = 0;
        check("busy_rise", clear_busy, 1);
        tick(); tick();
        clear_start = 1;
        tick();
        clear_start = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (!clear_busy) break;
        end
        check("busy_fell", clear_busy, 0);
        check("done_pulse", clear_done, 1);
        check("a_after_clear", {a_ready, b_ready}, 2'b10);
        push(1, 1, 4);
`ifdef VRAM_WRITE_CTRL_DROP_CNT_EN
        check("drop_cleared", drop_cnt, 0);
`endif
        tick();
        a_valid = 0;
        check("done_one_cycle", clear_done, 0);
        tick();
        busy_snap = busy_cnt;
        check("busy_cycles", busy_snap, 12);
        check("done_count", done_cnt, 1);

        // Reset during clear at pixel 5.
        clear_start = 1;
        push(0, 0, 0); push(1, 0, 0); push(2, 0, 0); push(3, 0, 0); push(0, 1, 0);
        tick();
        clear_start = 0;
        for (int n = 0; n < 5; n++) tick();
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        check("abort_wen",   wen, 0);
        check("abort_addr",  {waddr_x, waddr_y, wdata}, 0);
        check("abort_flags", {clear_busy, clear_done}, 0);
        tick(); tick();
        rst_n = 1;
        a_valid = 1; a_x = 3; a_y = 0; a_data = 5;
        #1 check("a_after_reset", {a_ready, b_ready}, 2'b10);
        push(3, 0, 5);
        tick();
        a_valid = 0;
        for (int n = 0; n < 4; n++) tick();
        check("abort_no_done", done_cnt, 1);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
